afu_wr_delay: RTL and testbench

Per-channel write-response latency injector for the CXL Type-3 AFU, sitting on the AXI4 write path between the CXL IP (host side) and the memory controller (MC side). It records every accepted AW beat in an in-order tracking queue and holds the MC's B response until a programmable per-entry delay has expired. It is the write-direction counterpart of the AFU read-response delay path and is instantiated once per MC channel. W-channel signals bypass this block.

---
 rtl/afu_wr_delay_pkg.sv | 17 +
 rtl/afu_jitter_lfsr.sv | 17 +
 rtl/afu_wr_delay.sv | 117 +++++++++++
 tb/tb_afu_wr_delay.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/afu_wr_delay_pkg.sv
// rtl/afu_wr_delay_pkg.sv - shared types and constants for the AFU write-response delay path
package afu_wr_delay_pkg;

    localparam int          AFU_ID_W    = 8;
    localparam int          AFU_CNT_W   = 7;
    localparam int unsigned DELAY_RST   = 64;
    localparam logic [56:0] DELAY_MAGIC = 57'h0A5_5A5A_5A5A_5A5A;

    // One tracking-queue slot; field widths follow the AFU's AXI ID and delay counter widths.
    typedef struct packed {
        logic                 valid;
        logic                 bdone;
        logic [AFU_ID_W-1:0]  id;
        logic [AFU_CNT_W-1:0] cnt;
    } t_wr_ent;

endpackage

// File: rtl/afu_jitter_lfsr.sv
// rtl/afu_jitter_lfsr.sv - free-running 8-bit maximal LFSR used to jitter the write-response delay
module afu_jitter_lfsr (
    input  logic       afu_clk,
    input  logic       afu_rst,
    output logic [7:0] lfsr
);

    // x^8 + x^6 + x^5 + x^4 + 1
    always_ff @(posedge afu_clk or posedge afu_rst) begin
        if (afu_rst) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

endmodule

// File: rtl/afu_wr_delay.sv
// rtl/afu_wr_delay.sv - per-channel AXI write-response latency injector; AFU_WR_JITTER_EN adds LFSR jitter
module afu_wr_delay #(
    parameter int          DEPTH       = 16,
    parameter int          ID_W        = afu_wr_delay_pkg::AFU_ID_W,
    parameter int          CNT_W       = afu_wr_delay_pkg::AFU_CNT_W,
    parameter int unsigned DELAY_RST   = afu_wr_delay_pkg::DELAY_RST,
    parameter logic [56:0] DELAY_MAGIC = afu_wr_delay_pkg::DELAY_MAGIC
) (
    input  logic                     afu_clk,
    input  logic                     afu_rst,
    input  logic [63:0]              cfg_data,
    input  logic                     h_awvalid,
    output logic                     h_awready,
    input  logic [ID_W-1:0]          h_awid,
    output logic                     mc_awvalid,
    input  logic                     mc_awready,
    input  logic                     mc_bvalid,
    output logic                     mc_bready,
    output logic                     h_bvalid,
    input  logic                     h_bready,
    output logic [ID_W-1:0]          h_bid,
    output logic [1:0]               h_bresp,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err_orphan
);

    import afu_wr_delay_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    t_wr_ent          ents [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, b_ptr;
    logic [AW-1:0]    widx, ridx, bidx;
    logic [CNT_W-1:0] delay_q;
    logic [CNT_W-1:0] load_delay;
    logic             full;
    logic             alloc, release_b, b_take;

    assign widx = wr_ptr[AW-1:0];
    assign ridx = rd_ptr[AW-1:0];
    assign bidx = b_ptr[AW-1:0];

    assign full        = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign outstanding = wr_ptr - rd_ptr;

    assign h_awready  = mc_awready && !full;
    assign mc_awvalid = h_awvalid && !full;
    assign mc_bready  = 1'b1;
    assign h_bresp    = 2'b00;

    assign h_bvalid = ents[ridx].valid && ents[ridx].bdone && (ents[ridx].cnt == '0);
    assign h_bid    = ents[ridx].id;

    assign alloc     = mc_awvalid && mc_awready;
    assign release_b = h_bvalid && h_bready;
    // MC responses are in order, so only the oldest not-yet-answered entry can take one.
    assign b_take    = mc_bvalid && ents[bidx].valid && !ents[bidx].bdone;

`ifdef AFU_WR_JITTER_EN
    logic [7:0]     lfsr;
    logic [CNT_W:0] jit_sum;

    afu_jitter_lfsr u_jitter_lfsr (
        .afu_clk (afu_clk),
        .afu_rst (afu_rst),
        .lfsr    (lfsr)
    );

    assign jit_sum    = {1'b0, delay_q} + (CNT_W+1)'(lfsr[2:0]);
    assign load_delay = jit_sum[CNT_W] ? {CNT_W{1'b1}} : jit_sum[CNT_W-1:0];
`else
    assign load_delay = delay_q;
`endif

    always_ff @(posedge afu_clk or posedge afu_rst) begin
        if (afu_rst) begin
            delay_q <= CNT_W'(DELAY_RST);
        end else if (cfg_data[63:7] == DELAY_MAGIC) begin
            delay_q <= CNT_W'(cfg_data[6:0]);
        end
    end

    always_ff @(posedge afu_clk or posedge afu_rst) begin
        if (afu_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            b_ptr      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (alloc)     wr_ptr <= wr_ptr + 1'b1;
            if (release_b) rd_ptr <= rd_ptr + 1'b1;
            if (b_take)    b_ptr  <= b_ptr + 1'b1;
            if (mc_bvalid && !b_take) err_orphan <= 1'b1;
        end
    end

    // Counters run independently of bdone so B arrival and delay expiry overlap.
    always_ff @(posedge afu_clk or posedge afu_rst) begin
        if (afu_rst) begin
            for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ents[i].valid && ents[i].cnt != '0) ents[i].cnt <= ents[i].cnt - 1'b1;
            end
            if (b_take)    ents[bidx].bdone <= 1'b1;
            if (release_b) ents[ridx] <= '0;
            if (alloc) begin
                ents[widx].valid <= 1'b1;
                ents[widx].bdone <= 1'b0;
                ents[widx].id    <= h_awid;
                ents[widx].cnt   <= load_delay;
            end
        end
    end

endmodule

// File: tb/tb_afu_wr_delay.sv
// tb/tb_afu_wr_delay.sv - randomized self-checking bench for afu_wr_delay against a timestamp model
module tb_afu_wr_delay;

    import afu_wr_delay_pkg::*;

    localparam int DEPTH = 16;
    localparam int ID_W  = 8;

    logic            afu_clk = 1'b0;
    logic            afu_rst;
    logic [63:0]     cfg_data;
    logic            h_awvalid, h_awready, mc_awvalid, mc_awready;
    logic [ID_W-1:0] h_awid, h_bid;
    logic            mc_bvalid, mc_bready, h_bvalid, h_bready;
    logic [1:0]      h_bresp;
    logic [4:0]      outstanding;
    logic            err_orphan;

    afu_wr_delay dut (
        .afu_clk     (afu_clk),
        .afu_rst     (afu_rst),
        .cfg_data    (cfg_data),
        .h_awvalid   (h_awvalid),
        .h_awready   (h_awready),
        .h_awid      (h_awid),
        .mc_awvalid  (mc_awvalid),
        .mc_awready  (mc_awready),
        .mc_bvalid   (mc_bvalid),
        .mc_bready   (mc_bready),
        .h_bvalid    (h_bvalid),
        .h_bready    (h_bready),
        .h_bid       (h_bid),
        .h_bresp     (h_bresp),
        .outstanding (outstanding),
        .err_orphan  (err_orphan)
    );

    always #5 afu_clk = ~afu_clk;

    // A write is releasable once both its delay (counted from the alloc edge) and its B edge have passed.
    typedef struct {
        int id;
        int a_edge;
        int dly;
        int b_edge;
    } t_txn;

    t_txn q[$];
    int   m_delay;
    bit   m_orphan;
    int   cyc;
    int   n_chk;
    int   n_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit exp_bvalid();
        if (q.size() == 0) return 1'b0;
        if (q[0].b_edge < 0) return 1'b0;
        return (cyc >= q[0].a_edge + q[0].dly) && (cyc >= q[0].b_edge);
    endfunction

    function automatic logic [63:0] magic(input int d);
        logic [6:0] dv;
        dv = 7'(d);
        return {DELAY_MAGIC, dv};
    endfunction

    task automatic tick(input bit aw, input logic [7:0] id, input bit awr,
                        input bit bv, input bit br, input logic [63:0] cfg);
        bit full, alloc, rel, e_bv;
        int nb, e;
        h_awvalid = aw; h_awid = id; mc_awready = awr;
        mc_bvalid = bv; h_bready = br; cfg_data = cfg;
        #1;
        full = (q.size() == DEPTH);
        e_bv = exp_bvalid();
        check("outstanding", 64'(outstanding), 64'(q.size()));
        check("h_awready", 64'(h_awready), 64'(awr && !full));
        check("mc_awvalid", 64'(mc_awvalid), 64'(aw && !full));
        check("h_bvalid", 64'(h_bvalid), 64'(e_bv));
        if (e_bv) check("h_bid", 64'(h_bid), 64'(q[0].id));
        check("err_orphan", 64'(err_orphan), 64'(m_orphan));
        check("mc_bready", 64'(mc_bready), 64'd1);
        check("h_bresp", 64'(h_bresp), 64'd0);
        alloc = aw && awr && !full;
        rel   = e_bv && br;
        e     = cyc + 1;
        if (bv) begin
            nb = 0;
            foreach (q[i]) if (q[i].b_edge >= 0) nb++;
            if (nb < q.size()) q[nb].b_edge = e;
            else m_orphan = 1'b1;
        end
        @(posedge afu_clk);
        cyc = e;
        if (rel) void'(q.pop_front());
        if (alloc) q.push_back('{int'(id), e, m_delay, -1});
        if (cfg[63:7] == DELAY_MAGIC) m_delay = int'(cfg[6:0]);
        #1;
    endtask

    task automatic idle(input int n, input bit br);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b1, 1'b0, br, 64'd0);
    endtask

    task automatic do_reset();
        afu_rst = 1'b1;
        h_awvalid = 1'b0; mc_awready = 1'b1; mc_bvalid = 1'b0;
        h_bready = 1'b0; cfg_data = 64'd0; h_awid = '0;
        #1;
        check("rst_h_bvalid", 64'(h_bvalid), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_err_orphan", 64'(err_orphan), 64'd0);
        check("rst_mc_bready", 64'(mc_bready), 64'd1);
        check("rst_h_awready", 64'(h_awready), 64'd1);
        @(posedge afu_clk);
        cyc++;
        #1;
        afu_rst = 1'b0;
        q.delete();
        m_delay  = 64;
        m_orphan = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_err = 0; cyc = 0;
        do_reset();

        // Reset delay of 64 on the first write, 20 on the second, released in order.
        tick(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 64'd0);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, magic(20));
        tick(1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 64'd0);
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 64'd0);
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 64'd0);
        idle(70, 1'b1);

        // Delay 10, B three cycles after the AW handshake.
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, magic(10));
        tick(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 64'd0);
        idle(2, 1'b1);
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 64'd0);
        idle(12, 1'b1);

        // Delay 0, B five cycles after AW: one cycle of B-to-host latency.
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, magic(0));
        tick(1'b1, 8'h47, 1'b1, 1'b0, 1'b1, 64'd0);
        idle(4, 1'b1);
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 64'd0);
        idle(4, 1'b1);

        // Fill all sixteen entries, hold AW against the full queue, then free one slot.
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 3; i++)  tick(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 64'd0);
        tick(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 64'd0);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 64'd0);
        tick(1'b1, 8'hEF, 1'b1, 1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 16; i++) tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 64'd0);
        idle(5, 1'b1);

        // Host back-pressure while a response is pending, then alloc concurrent with release.
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, magic(2));
        tick(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 64'd0);
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 64'd0);
        idle(10, 1'b0);
        tick(1'b1, 8'h6B, 1'b1, 1'b0, 1'b1, 64'd0);
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 64'd0);
        idle(6, 1'b1);

        // Random traffic with occasional delay updates and non-matching config words.
        for (int i = 0; i < 900; i++) begin
            logic [63:0] cfg;
            int r;
            r = $urandom_range(0, 99);
            if (r < 5)       cfg = magic($urandom_range(0, 12));
            else if (r < 8)  cfg = {DELAY_MAGIC ^ 57'd1, 7'($urandom_range(0, 127))};
            else             cfg = 64'd0;
            tick($urandom_range(0, 99) < 45, 8'($urandom), $urandom_range(0, 99) < 75,
                 $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 70, cfg);
        end

        // Reset with writes in flight discards them and clears the sticky error.
        tick(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 64'd0);
        tick(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 64'd0);
        do_reset();
        idle(3, 1'b1);

        // Orphan B on an empty queue sets the error, which then stays set.
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 64'd0);
        idle(6, 1'b1);
        tick(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, magic(1));
        tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 64'd0);
        idle(6, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
